// File: rtl/button_debouncer.sv
// Per-channel 2-flop synchronizer and debouncer for raw push-button pins.
// Each channel gives a clean level plus one-cycle press and release pulses.
module button_debouncer #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 500000,
    parameter int CNT_W         = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn_in,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release
);

    // state   | meaning
    // LOW     | accepted level 0, watching for a rising input
    // WAIT_HI | input went high, counting stable-high cycles
    // HIGH    | accepted level 1, watching for a falling input
    // WAIT_LO | input went low, counting stable-low cycles
    typedef enum logic [1:0] {
        LOW     = 2'd0,
        WAIT_HI = 2'd1,
        HIGH    = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q1;
    logic [WIDTH-1:0] sync_q2;
    state_t           state [WIDTH];
    logic [CNT_W-1:0] cnt   [WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1     <= '0;
            sync_q2     <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                state[i] <= LOW;
                cnt[i]   <= '0;
            end
        end else begin
            sync_q1     <= btn_in;
            sync_q2     <= sync_q1;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                case (state[i])
                    LOW: begin
                        if (sync_q2[i]) begin
                            state[i] <= WAIT_HI;
                            cnt[i]   <= '0;
                        end
                    end
                    WAIT_HI: begin
                        if (!sync_q2[i]) begin
                            state[i] <= LOW;
                        end else if (cnt[i] == CNT_LAST) begin
                            state[i]     <= HIGH;
                            btn_level[i] <= 1'b1;
                            btn_press[i] <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                    HIGH: begin
                        if (!sync_q2[i]) begin
                            state[i] <= WAIT_LO;
                            cnt[i]   <= '0;
                        end
                    end
                    WAIT_LO: begin
                        // a return to high mid-count is bounce; level never dropped
                        if (sync_q2[i]) begin
                            state[i] <= HIGH;
                        end else if (cnt[i] == CNT_LAST) begin
                            state[i]       <= LOW;
                            btn_level[i]   <= 1'b0;
                            btn_release[i] <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                    default: begin
                        state[i] <= LOW;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: a run-length model predicts outputs
// each posedge, and the prediction is compared on the following negedge.
module tb_button_debouncer;

    localparam int W  = 4;
    localparam int SC = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] btn_in = '0;
    logic [W-1:0] btn_level;
    logic [W-1:0] btn_press;
    logic [W-1:0] btn_release;

    button_debouncer #(.WIDTH(W), .STABLE_CYCLES(SC), .CNT_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: level flips once the synchronized input has disagreed
    // with it for SC+1 consecutive edges.
    logic [W-1:0]     m_s1 = '0, m_s2 = '0, m_lvl = '0, m_press = '0, m_rel = '0;
    int               run [W];
    logic [3*W-1:0]   sb_q [$];

    always @(posedge clk) begin
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_rel = '0;
            for (int i = 0; i < W; i++) run[i] = 0;
        end else begin
            m_press = '0;
            m_rel   = '0;
            for (int i = 0; i < W; i++) begin
                if (m_s2[i] != m_lvl[i]) run[i] = run[i] + 1;
                else run[i] = 0;
                if (run[i] == SC + 1) begin
                    m_lvl[i] = ~m_lvl[i];
                    if (m_lvl[i]) m_press[i] = 1'b1;
                    else m_rel[i] = 1'b1;
                    run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = btn_in;
        end
        sb_q.push_back({m_lvl, m_press, m_rel});
    end

    int press_cnt [W];
    int rel_cnt   [W];
    logic [3*W-1:0] exp_v;

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_v = sb_q.pop_front();
            check("outputs", {btn_level, btn_press, btn_release}, exp_v);
            check("press_release_excl", btn_press & btn_release, 0);
            for (int i = 0; i < W; i++) begin
                if (btn_press[i] === 1'b1) press_cnt[i]++;
                if (btn_release[i] === 1'b1) rel_cnt[i]++;
            end
        end
    end

    task automatic clear_counts();
        for (int i = 0; i < W; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i]   = 0;
        end
    endtask

    initial begin
        clear_counts();
        reset  = 1'b1;
        btn_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // idle after reset
        repeat (20) @(negedge clk);
        check("t1_level", btn_level, 0);
        check("t1_press_cnt", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
        check("t1_rel_cnt", rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3], 0);

        // clean press on channel 0: level visible after edge E+6
        btn_in[0] = 1'b1;
        repeat (6) @(negedge clk);
        check("t2_level_early", btn_level[0], 0);
        @(negedge clk);
        check("t2_level", btn_level[0], 1);
        check("t2_press", btn_press[0], 1);
        @(negedge clk);
        check("t2_press_gone", btn_press[0], 0);
        repeat (5) @(negedge clk);
        check("t2_press_cnt", press_cnt[0], 1);
        check("t2_rel_cnt", rel_cnt[0], 0);

        // bouncy glitches on channel 1 never accepted
        btn_in[1] = 1'b1; repeat (3) @(negedge clk);
        btn_in[1] = 1'b0; repeat (2) @(negedge clk);
        btn_in[1] = 1'b1; repeat (2) @(negedge clk);
        btn_in[1] = 1'b0; repeat (15) @(negedge clk);
        check("t3_level", btn_level[1], 0);
        check("t3_press_cnt", press_cnt[1], 0);

        // release on channel 2
        btn_in[2] = 1'b1;
        repeat (12) @(negedge clk);
        check("t4_level_hi", btn_level[2], 1);
        btn_in[2] = 1'b0;
        repeat (6) @(negedge clk);
        check("t4_level_early", btn_level[2], 1);
        @(negedge clk);
        check("t4_level", btn_level[2], 0);
        check("t4_release", btn_release[2], 1);
        repeat (6) @(negedge clk);
        check("t4_rel_cnt", rel_cnt[2], 1);

        // reset mid-WAIT_HI on channel 3, button held through reset
        btn_in[3] = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_reset_level", btn_level, 0);
        check("t5_reset_press", btn_press, 0);
        check("t5_press_none", press_cnt[3], 0);
        reset = 1'b0;
        clear_counts();
        repeat (6) @(negedge clk);
        check("t5_press_early", btn_press[3], 0);
        @(negedge clk);
        check("t5_press", btn_press[3], 1);
        repeat (10) @(negedge clk);
        check("t5_press_cnt", press_cnt[3], 1);

        // all channels at once
        btn_in = '0;
        repeat (15) @(negedge clk);
        check("t6_idle", btn_level, 0);
        clear_counts();
        btn_in = '1;
        for (int i = 0; i < 20 && btn_press == '0; i++) @(negedge clk);
        check("t6_press_all", btn_press, 4'hf);
        check("t6_level_all", btn_level, 4'hf);
        repeat (5) @(negedge clk);
        for (int i = 0; i < W; i++) check("t6_press_cnt", press_cnt[i], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
